// File: rtl/gray_ptr_counter.sv
// gray_ptr_counter: pointer engine for one side of an asynchronous FIFO.
// Keeps a binary and a registered Gray pointer in the local clock domain,
// synchronises the remote Gray pointer through SYNC_STAGES flops and
// produces a registered full (MODE 0) or empty (MODE 1) flag.
// Optional feature macro: GRAYPTR_LEVEL_EN adds the level port/register.
module gray_ptr_counter #(
   parameter int ADDR_W      = 5,
   parameter int SYNC_STAGES = 2,
   parameter int MODE        = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   input  logic [ADDR_W:0]   remote_gray,
   output logic [ADDR_W:0]   ptr_bin,
   output logic [ADDR_W:0]   ptr_gray,
   output logic [ADDR_W-1:0] addr,
   output logic              flag
`ifdef GRAYPTR_LEVEL_EN
   ,
   output logic [ADDR_W:0]   level
`endif
);

   localparam logic FLAG_RST = (MODE != 0);

   logic [ADDR_W:0] r_bin;
   logic [ADDR_W:0] r_gray;
   logic            r_flag;
   logic [ADDR_W:0] r_sync [SYNC_STAGES];

   logic            w_advance;
   logic [ADDR_W:0] w_bin_next;
   logic [ADDR_W:0] w_gray_next;
   logic [ADDR_W:0] w_rsync;
   logic [ADDR_W:0] w_full_cmp;
   logic            w_flag_next;

   assign w_advance   = inc & ~r_flag;
   assign w_bin_next  = r_bin + {{ADDR_W{1'b0}}, w_advance};
   assign w_gray_next = w_bin_next ^ {1'b0, w_bin_next[ADDR_W:1]};
   assign w_rsync     = r_sync[SYNC_STAGES-1];
   // Full when the local pointer is exactly one lap ahead of the remote one:
   // in Gray code that is the top two bits inverted, the rest equal.
   assign w_full_cmp  = {~w_rsync[ADDR_W:ADDR_W-1], w_rsync[ADDR_W-2:0]};

   // Flag condition evaluated on the next local pointer so it never lags a local advance
   always_comb begin
      w_flag_next = 1'b0;
      if (MODE == 0)
         w_flag_next = (w_gray_next == w_full_cmp);
      else
         w_flag_next = (w_gray_next == w_rsync);
   end

   // Plain flop chain capturing the asynchronous remote Gray pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++)
            r_sync[i] <= '0;
      end else begin
         r_sync[0] <= remote_gray;
         for (int unsigned i = 1; i < SYNC_STAGES; i++)
            r_sync[i] <= r_sync[i-1];
      end
   end

   // Local pointer pair and registered flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_flag <= FLAG_RST;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
         r_flag <= w_flag_next;
      end
   end

`ifdef GRAYPTR_LEVEL_EN
   logic [ADDR_W:0] r_level;
   logic [ADDR_W:0] w_remote_bin;

   // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i
   always_comb begin
      w_remote_bin = '0;
      for (int unsigned i = 0; i <= ADDR_W; i++)
         w_remote_bin[i] = ^(w_rsync >> i);
   end

   // Occupancy, modulo 2^(ADDR_W+1), based on the next local pointer
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_level <= '0;
      else if (MODE == 0)
         r_level <= w_bin_next - w_remote_bin;
      else
         r_level <= w_remote_bin - w_bin_next;
   end

   assign level = r_level;
`endif

   assign ptr_bin  = r_bin;
   assign ptr_gray = r_gray;
   assign addr     = r_bin[ADDR_W-1:0];
   assign flag     = r_flag;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Bench for gray_ptr_counter: one MODE 0 and one MODE 1 instance driven
// side by side. Level is checked when GRAYPTR_LEVEL_EN is defined.
module tb_gray_ptr_counter;

   logic       clk;
   logic       rst_n;
   logic       inc   [2];
   logic [5:0] rg    [2];
   logic [5:0] pb    [2];
   logic [5:0] pg    [2];
   logic [4:0] ad    [2];
   logic       fl    [2];
   logic [5:0] lv    [2];

   int n_total;
   int n_bad;

   typedef struct packed {
      logic [1:0][5:0] b;
      logic [1:0][5:0] l;
      logic [1:0]      f;
   } exp_t;

   exp_t sb_q[$];

   // reference model: pointers kept in binary, remote delayed in binary
   logic [5:0] mb  [2];
   logic       mf  [2];
   logic [5:0] ml  [2];
   logic [5:0] ms0 [2];
   logic [5:0] ms1 [2];

   gray_ptr_counter #(.ADDR_W(5), .SYNC_STAGES(2), .MODE(0)) u_wr (
      .clk(clk), .rst_n(rst_n), .inc(inc[0]), .remote_gray(rg[0]),
      .ptr_bin(pb[0]), .ptr_gray(pg[0]), .addr(ad[0]), .flag(fl[0])
`ifdef GRAYPTR_LEVEL_EN
      , .level(lv[0])
`endif
   );

   gray_ptr_counter #(.ADDR_W(5), .SYNC_STAGES(2), .MODE(1)) u_rd (
      .clk(clk), .rst_n(rst_n), .inc(inc[1]), .remote_gray(rg[1]),
      .ptr_bin(pb[1]), .ptr_gray(pg[1]), .addr(ad[1]), .flag(fl[1])
`ifdef GRAYPTR_LEVEL_EN
      , .level(lv[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // drive one cycle, predict, then compare after the edge
   task automatic cyc(input logic rn, input logic i0, input logic i1,
                      input logic [5:0] rb0, input logic [5:0] rb1);
      logic [5:0] rbv [2];
      logic       iv  [2];
      logic [5:0] nb, rs, d;
      exp_t e, g;
      rbv[0] = rb0; rbv[1] = rb1;
      iv[0]  = i0;  iv[1]  = i1;
      rst_n = rn;
      for (int m = 0; m < 2; m++) begin
         inc[m] = iv[m];
         rg[m]  = rbv[m] ^ (rbv[m] >> 1);
         if (!rn) begin
            mb[m] = '0; mf[m] = (m == 1); ml[m] = '0; ms0[m] = '0; ms1[m] = '0;
         end else begin
            nb = mb[m] + {5'd0, (iv[m] & ~mf[m])};
            rs = ms1[m];
            d  = nb - rs;
            mf[m]  = (m == 0) ? (d == 6'd32) : (nb == rs);
            ml[m]  = (m == 0) ? d : (rs - nb);
            ms1[m] = ms0[m];
            ms0[m] = rbv[m];
            mb[m]  = nb;
         end
         e.b[m] = mb[m]; e.l[m] = ml[m]; e.f[m] = mf[m];
      end
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      g = sb_q.pop_front();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("bin%0d", m),  pb[m], g.b[m]);
         chk($sformatf("gray%0d", m), pg[m], g.b[m] ^ (g.b[m] >> 1));
         chk($sformatf("addr%0d", m), ad[m], g.b[m][4:0]);
         chk($sformatf("flag%0d", m), fl[m], g.f[m]);
`ifdef GRAYPTR_LEVEL_EN
         chk($sformatf("level%0d", m), lv[m], g.l[m]);
`endif
      end
   endtask

   initial begin
      logic [5:0] r0, r1;
      n_total = 0;
      n_bad   = 0;
      rst_n = 1'b0;
      for (int m = 0; m < 2; m++) begin
         inc[m] = 1'b0; rg[m] = '0;
         mb[m] = '0; mf[m] = 1'b0; ml[m] = '0; ms0[m] = '0; ms1[m] = '0;
      end

      // reset with inc high
      cyc(1'b0, 1'b1, 1'b1, 6'd0, 6'd0);
      chk("rst_bin0", pb[0], 6'd0);
      chk("rst_gray0", pg[0], 6'h00);
      chk("rst_flag0", fl[0], 1'b0);
      chk("rst_flag1", fl[1], 1'b1);

      // fill the write side
      for (int i = 0; i < 31; i++) cyc(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
      chk("fill31_bin", pb[0], 6'd31);
      chk("fill31_gray", pg[0], 6'h10);
      chk("fill31_flag", fl[0], 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
      chk("fill32_bin", pb[0], 6'd32);
      chk("fill32_gray", pg[0], 6'h30);
      chk("fill32_flag", fl[0], 1'b1);
`ifdef GRAYPTR_LEVEL_EN
      chk("fill32_level", lv[0], 6'd32);
`endif

      // blocked incs while full
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
      chk("blk_bin", pb[0], 6'd32);
      chk("blk_gray", pg[0], 6'h30);
      chk("blk_flag", fl[0], 1'b1);
      // remote read pointer advances to 1: flag drops on the 3rd edge
      cyc(1'b1, 1'b0, 1'b0, 6'd1, 6'd0);
      cyc(1'b1, 1'b0, 1'b0, 6'd1, 6'd0);
      chk("rel_e2_flag", fl[0], 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 6'd1, 6'd0);
      chk("rel_e3_flag", fl[0], 1'b0);
`ifdef GRAYPTR_LEVEL_EN
      chk("rel_e3_level", lv[0], 6'd31);
`endif

      // read side: remote write pointer to 3
      cyc(1'b1, 1'b0, 1'b0, 6'd1, 6'd3);
      cyc(1'b1, 1'b0, 1'b0, 6'd1, 6'd3);
      chk("emp_e2_flag", fl[1], 1'b1);
      cyc(1'b1, 1'b0, 1'b0, 6'd1, 6'd3);
      chk("emp_e3_flag", fl[1], 1'b0);
`ifdef GRAYPTR_LEVEL_EN
      chk("emp_e3_level", lv[1], 6'd3);
`endif
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 6'd1, 6'd3);
      chk("emp_bin", pb[1], 6'd3);
      chk("emp_flag", fl[1], 1'b1);
      cyc(1'b1, 1'b0, 1'b1, 6'd1, 6'd3);
      chk("emp_ign_bin", pb[1], 6'd3);

      // wrap on the read side
      cyc(1'b0, 1'b0, 1'b0, 6'd0, 6'd63);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 6'd0, 6'd63);
      for (int i = 0; i < 63; i++) cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'd63);
      chk("wrap_bin63", pb[1], 6'd63);
      chk("wrap_gray63", pg[1], 6'h20);
      chk("wrap_flag63", fl[1], 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 6'd0, 6'd1);
`ifdef GRAYPTR_LEVEL_EN
      chk("wrap_level", lv[1], 6'd2);
`endif
      cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'd1);
      chk("wrap_bin0", pb[1], 6'd0);
      chk("wrap_gray0", pg[1], 6'h00);
      cyc(1'b1, 1'b0, 1'b1, 6'd0, 6'd1);
      chk("wrap_bin1", pb[1], 6'd1);
      chk("wrap_gray1", pg[1], 6'h01);
      chk("wrap_flag1", fl[1], 1'b1);

      // reset mid-run on the write side
      cyc(1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
      for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
      chk("mid_bin17", pb[0], 6'd17);
      cyc(1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
      chk("mid_rst_bin", pb[0], 6'd0);
      cyc(1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
      chk("mid_rel_flag", fl[0], 1'b0);
`ifdef GRAYPTR_LEVEL_EN
      chk("mid_rel_level", lv[0], 6'd0);
`endif
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 6'd0, 6'd0);
      cyc(1'b1, 1'b0, 1'b0, 6'd2, 6'd0);
      cyc(1'b1, 1'b0, 1'b0, 6'd2, 6'd0);
`ifdef GRAYPTR_LEVEL_EN
      chk("mid_e2_level", lv[0], 6'd3);
`endif
      cyc(1'b1, 1'b0, 1'b0, 6'd2, 6'd0);
`ifdef GRAYPTR_LEVEL_EN
      chk("mid_e3_level", lv[0], 6'd1);
`endif

      // random traffic, checked against the model every cycle
      r0 = 6'd2;
      r1 = 6'd0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r0 = 6'($urandom);
         if ($urandom_range(0, 3) == 0) r1 = 6'($urandom);
         cyc(($urandom_range(0, 60) != 0), 1'($urandom), 1'($urandom), r0, r1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
